// File: rtl/micro_mc.sv
// micro_mc: multicycle FETCH/EXEC core with internal IRAM, 16-entry register file,
// hardware return stack, WAIT-for-button, HALT and sticky stack-fault detection.
module micro_mc #(
  parameter int WIDTH          = 16,
  parameter int IRAM_ADDR_BITS = 8,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IRAM_ADDR_BITS-1:0]   iram_wa,
  input  logic                        iram_wen,
  input  logic [WIDTH-1:0]            iram_din,
  input  logic                        PCenable,
  input  logic                        extCtl,
  input  logic [3:0]                  monRFSrc,
  output logic [WIDTH-1:0]            monRFData,
  output logic [WIDTH-1:0]            monInstr,
  output logic [2*IRAM_ADDR_BITS-1:0] monPC,
  output logic                        led,
  output logic                        halted,
  output logic                        fault
);

  localparam int AB     = IRAM_ADDR_BITS;
  localparam int SPW    = $clog2(STACK_DEPTH + 1);
  localparam int SIW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SDEPTH = 1 << SIW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAITX, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [AB-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             z_q, z_d, n_q, n_d;
  logic             led_q, led_d;
  logic             fault_q, fault_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] rf_q [16];
  logic [WIDTH-1:0] rf_d [16];
  logic [AB-1:0]    stk_q [SDEPTH];
  logic [AB-1:0]    stk_d [SDEPTH];

  // IRAM contents are deliberately not reset; the read is sampled into instr_q
  // so a same-cycle write to the fetched address yields the old word.
  logic [WIDTH-1:0] iram [0:(1<<AB)-1];

  always_ff @(posedge clk) begin
    if (iram_wen) iram[iram_wa] <= iram_din;
  end

  logic [3:0]       op, rd, rb, ra;
  logic [7:0]       imm8;
  logic [WIDTH-1:0] ra_val, rb_val, rd_val, imm_zext;
  logic [AB-1:0]    br_off, call_tgt, pc_inc, pc_br, exec_pc, pc_next;
  logic [SIW-1:0]   push_idx, pop_idx;
  logic             stack_full, stack_empty;
  logic [WIDTH-1:0] alu_res;

  assign op       = instr_q[15:12];
  assign rd       = instr_q[11:8];
  assign rb       = instr_q[7:4];
  assign ra       = instr_q[3:0];
  assign imm8     = instr_q[7:0];
  assign ra_val   = rf_q[ra];
  assign rb_val   = rf_q[rb];
  assign rd_val   = rf_q[rd];
  assign imm_zext = WIDTH'(imm8);
  assign br_off   = AB'($signed(imm8));
  assign call_tgt = AB'(imm8);
  assign pc_inc   = pc_q + 1'b1;
  assign pc_br    = pc_q + br_off;

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign push_idx    = sp_q[SIW-1:0];
  assign pop_idx     = push_idx - 1'b1;

  always_comb begin
    alu_res = '0;
    case (op)
      4'h0:    alu_res = ra_val + rb_val;
      4'h1:    alu_res = ra_val - rb_val;
      4'h2:    alu_res = ra_val & rb_val;
      4'h3:    alu_res = ra_val | rb_val;
      default: alu_res = '0;
    endcase
  end

  // Faulting CALL/RET leave the PC where it is.
  always_comb begin
    exec_pc = pc_inc;
    case (op)
      4'h6:    exec_pc = z_q ? pc_br : pc_inc;
      4'h7:    exec_pc = pc_br;
      4'h8:    exec_pc = pc_q;
      4'h9:    exec_pc = stack_full ? pc_q : call_tgt;
      4'hA:    exec_pc = stack_empty ? pc_q : stk_q[pop_idx];
      default: exec_pc = pc_inc;
    endcase
    pc_next = (state_q == S_EXEC) ? exec_pc : pc_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    z_d     = z_q;
    n_d     = n_q;
    led_d   = led_q;
    fault_d = fault_q;
    sp_d    = sp_q;
    rf_d    = rf_q;
    stk_d   = stk_q;

    if (PCenable) begin
      unique case (state_q)
        S_FETCH: begin
          instr_d = iram[pc_q];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          pc_d    = exec_pc;
          state_d = S_FETCH;
          case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              rf_d[rd] = alu_res;
              z_d      = (alu_res == '0);
              n_d      = alu_res[WIDTH-1];
            end
            4'h4: rf_d[rd] = imm_zext;
            4'h5: rf_d[rd] = (rd_val << 8) | imm_zext;
            4'h8: state_d = S_WAITX;
            4'h9: begin
              if (stack_full) begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                stk_d[push_idx] = pc_inc;
                sp_d            = sp_q + 1'b1;
              end
            end
            4'hA: begin
              if (stack_empty) begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                sp_d = sp_q - 1'b1;
              end
            end
            4'hB: led_d = rd_val[0];
            4'hF: state_d = S_HALT;
            default: ;
          endcase
        end
        S_WAITX: begin
          if (extCtl) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      led_q   <= 1'b0;
      fault_q <= 1'b0;
      sp_q    <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      z_q     <= z_d;
      n_q     <= n_d;
      led_q   <= led_d;
      fault_q <= fault_d;
      sp_q    <= sp_d;
      rf_q    <= rf_d;
      stk_q   <= stk_d;
    end
  end

  assign monRFData = rf_q[monRFSrc];
  assign monInstr  = instr_q;
  assign monPC     = {pc_q, pc_next};
  assign led       = led_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_micro_mc.sv
// Bench for micro_mc: table-driven ALU/flag programs plus hand sequences for
// branches, WAIT, call stack, faults, freeze, reset and PC wrap.
module tb_micro_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  iram_wa = '0;
  logic        iram_wen = 1'b0;
  logic [15:0] iram_din = '0;
  logic        PCenable = 1'b0;
  logic        extCtl = 1'b0;
  logic [3:0]  monRFSrc = '0;
  logic [15:0] monRFData, monInstr, monPC;
  logic        led, halted, fault;

  micro_mc dut (
    .clk(clk), .reset(reset), .iram_wa(iram_wa), .iram_wen(iram_wen),
    .iram_din(iram_din), .PCenable(PCenable), .extCtl(extCtl),
    .monRFSrc(monRFSrc), .monRFData(monRFData), .monInstr(monInstr),
    .monPC(monPC), .led(led), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { string name; logic [3:0] r; logic [15:0] v; } rexp_t;
  rexp_t       sbq[$];
  logic [15:0] pcq[$];

  typedef struct { logic [3:0] op; logic [7:0] a; logic [7:0] b; logic [15:0] res; logic nz; } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    PCenable = 1'b0;
    extCtl   = 1'b0;
    iram_wen = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    iram_wa  = a;
    iram_din = d;
    iram_wen = 1'b1;
    step();
    iram_wen = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [3:0] r, input logic [15:0] v);
    rexp_t e;
    e.name = name; e.r = r; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    rexp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      monRFSrc = e.r;
      #1;
      chk(e.name, monRFData, e.v);
    end
    step();
  endtask

  task automatic run_halt(input string name, output int n);
    PCenable = 1'b1;
    n = 0;
    while (!halted && n < 300) begin
      step();
      n++;
    end
    if (!halted) chk({name, "_timeout"}, 0, 1);
    PCenable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'h0, 8'h05, 8'h03, 16'h0008, 1'b1};
    vecs[1] = '{4'h0, 8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[2] = '{4'h0, 8'hFF, 8'h01, 16'h0100, 1'b1};
    vecs[3] = '{4'h1, 8'h00, 8'h01, 16'hFFFF, 1'b1};
    vecs[4] = '{4'h1, 8'h05, 8'h05, 16'h0000, 1'b0};
    vecs[5] = '{4'h1, 8'h03, 8'h05, 16'hFFFE, 1'b1};
    vecs[6] = '{4'h2, 8'hF0, 8'h3C, 16'h0030, 1'b1};
    vecs[7] = '{4'h2, 8'hF0, 8'h0F, 16'h0000, 1'b0};
    vecs[8] = '{4'h3, 8'hA0, 8'h05, 16'h00A5, 1'b1};
    vecs[9] = '{4'h3, 8'h00, 8'h00, 16'h0000, 1'b0};

    // Reset state
    do_reset();
    chk("rst_monPC", monPC, 16'h0000);
    chk("rst_instr", monInstr, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_led", led, 0);
    expect_reg("rst_r0", 4'd0, 16'h0000);
    expect_reg("rst_r15", 4'd15, 16'h0000);
    drain();

    // LDL/LDL/SUB/HALT: eight cycles to halted
    wr(8'h00, 16'h4105); wr(8'h01, 16'h4203); wr(8'h02, 16'h1321); wr(8'h03, 16'hF000);
    PCenable = 1'b1;
    step();
    chk("p1_first_fetch", monInstr, 16'h4105);
    run_halt("p1", n);
    chk("p1_cycles", 1 + n, 8);
    chk("p1_monPC", monPC, 16'h0404);
    chk("p1_fault", fault, 0);
    expect_reg("p1_r3", 4'd3, 16'h0002);
    drain();

    // ALU table; BZ skips "LDL r4,1" when the result is zero
    for (int i = 0; i < 10; i++) begin
      do_reset();
      wr(8'h00, {4'h4, 4'd1, vecs[i].a});
      wr(8'h01, {4'h4, 4'd2, vecs[i].b});
      wr(8'h02, {vecs[i].op, 4'd3, 4'd2, 4'd1});
      wr(8'h03, 16'h6002);
      wr(8'h04, 16'h4401);
      wr(8'h05, 16'hF000);
      run_halt($sformatf("alu%0d", i), n);
      expect_reg($sformatf("alu%0d_res", i), 4'd3, vecs[i].res);
      expect_reg($sformatf("alu%0d_zflag", i), 4'd4, {15'd0, vecs[i].nz});
      drain();
    end

    // Counter loop: BZ taken once, 11 instructions
    do_reset();
    wr(8'h00, 16'h4103); wr(8'h01, 16'h4201); wr(8'h02, 16'h1121);
    wr(8'h03, 16'h6002); wr(8'h04, 16'h70FE); wr(8'h05, 16'hF000);
    run_halt("loop", n);
    chk("loop_cycles", n, 22);
    chk("loop_monPC", monPC, 16'h0606);
    expect_reg("loop_r1", 4'd1, 16'h0000);
    drain();

    // Freeze for five cycles mid-EXEC, then resume
    do_reset();
    PCenable = 1'b1;
    repeat (3) step();
    chk("frz_pre_monPC", monPC, 16'h0102);
    PCenable = 1'b0;
    repeat (5) step();
    chk("frz_monPC", monPC, 16'h0102);
    chk("frz_instr", monInstr, 16'h4201);
    chk("frz_halted", halted, 0);
    run_halt("frz", n);
    chk("frz_total_cycles", 3 + n, 22);
    expect_reg("frz_r1", 4'd1, 16'h0000);
    expect_reg("frz_r2", 4'd2, 16'h0001);
    drain();

    // LDH shifting, upper bits discarded
    do_reset();
    wr(8'h00, 16'h4412); wr(8'h01, 16'h5434); wr(8'h02, 16'h46AB);
    wr(8'h03, 16'h56CD); wr(8'h04, 16'h56EF); wr(8'h05, 16'hF000);
    run_halt("ldh", n);
    expect_reg("ldh_r4", 4'd4, 16'h1234);
    expect_reg("ldh_r6", 4'd6, 16'hCDEF);
    drain();

    // WAIT holds until extCtl, ignores extCtl while frozen
    do_reset();
    wr(8'h00, 16'h8000); wr(8'h01, 16'h4709); wr(8'h02, 16'hF000);
    PCenable = 1'b1;
    step(); step();
    repeat (10) step();
    chk("wait_hold_monPC", monPC, 16'h0000);
    chk("wait_hold_halted", halted, 0);
    PCenable = 1'b0;
    extCtl   = 1'b1;
    step(); step();
    chk("wait_frozen_monPC", monPC, 16'h0000);
    PCenable = 1'b1;
    step();
    chk("wait_release_monPC", monPC, 16'h0101);
    extCtl = 1'b0;
    run_halt("wait", n);
    chk("wait_end_monPC", monPC, 16'h0303);
    expect_reg("wait_r7", 4'd7, 16'h0009);
    drain();

    // CALL nesting to full depth then RET chain
    do_reset();
    wr(8'h00, 16'h9010); wr(8'h01, 16'hF000);
    wr(8'h10, 16'h9020); wr(8'h11, 16'hA000);
    wr(8'h20, 16'h9030); wr(8'h21, 16'hA000);
    wr(8'h30, 16'h9040); wr(8'h31, 16'hA000);
    wr(8'h40, 16'h4877); wr(8'h41, 16'hA000);
    pcq = '{16'h0010, 16'h1020, 16'h2030, 16'h3040, 16'h4041,
            16'h4131, 16'h3121, 16'h2111, 16'h1101, 16'h0102};
    PCenable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] e;
      step();
      e = pcq.pop_front();
      chk($sformatf("call_exec%0d", i), monPC, e);
      step();
    end
    PCenable = 1'b0;
    chk("call_halted", halted, 1);
    chk("call_fault", fault, 0);
    expect_reg("call_r8", 4'd8, 16'h0077);
    drain();

    // One CALL too many
    wr(8'h40, 16'h9050); wr(8'h50, 16'hF000);
    do_reset();
    run_halt("ovf", n);
    chk("ovf_fault", fault, 1);
    chk("ovf_halted", halted, 1);
    chk("ovf_monPC", monPC, 16'h4040);

    // RET on an empty stack
    wr(8'h00, 16'hA000);
    do_reset();
    run_halt("unf", n);
    chk("unf_fault", fault, 1);
    chk("unf_monPC", monPC, 16'h0000);

    // OUT toggles led; reset mid-run clears everything
    do_reset();
    wr(8'h00, 16'h4501); wr(8'h01, 16'hB500); wr(8'h02, 16'h4500);
    wr(8'h03, 16'hB500); wr(8'h04, 16'hF000);
    PCenable = 1'b1;
    repeat (4) step();
    chk("out_led_on", led, 1);
    repeat (4) step();
    chk("out_led_off", led, 0);
    do_reset();
    monRFSrc = 4'd5;
    PCenable = 1'b1;
    repeat (4) step();
    chk("rstmid_led_pre", led, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_led", led, 0);
    chk("rstmid_monPC", monPC, 16'h0000);
    chk("rstmid_instr", monInstr, 16'h0000);
    chk("rstmid_r5", monRFData, 16'h0000);
    chk("rstmid_halted", halted, 0);
    step();
    reset = 1'b0;
    PCenable = 1'b0;

    // PC wrap via negative branch and NOP at the top address
    do_reset();
    wr(8'h00, 16'h70FF); wr(8'hFF, 16'hC000);
    PCenable = 1'b1;
    step();
    chk("wrap_bra_monPC", monPC, 16'h00FF);
    step(); step();
    chk("wrap_nop_monPC", monPC, 16'hFF00);
    step();
    chk("wrap_fetch_monPC", monPC, 16'h0000);
    PCenable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_mc.md
# micro_mc

Parametrised multicycle successor to the single-cycle 16-bit micro. It holds an internal instruction RAM with a write port that any loader can use, a 16-entry register file and a small ALU. A FETCH/EXEC state machine adds behaviour the single-cycle core lacks: conditional/relative branches, CALL/RET through a hardware return stack, a WAIT-for-button instruction, HALT, and fault detection. It sits at board top level between the program loader (UART/switches) and the seven-segment/LED monitor.

## Interface
- WIDTH, 16: datapath and instruction width; must be ≥16.
- IRAM_ADDR_BITS, 8: IRAM address bits; depth is 2^IRAM_ADDR_BITS.
- STACK_DEPTH, 4: return-stack entries; must be ≥1.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- iram_wa  input  IRAM_ADDR_BITS  IRAM write address.
- iram_wen  input  1  IRAM write enable.
- iram_din  input  WIDTH  IRAM write data.
- PCenable  input  1  run enable; low freezes the FSM, PC, registers and stack.
- extCtl  input  1  external control (button), already synchronised.
- monRFSrc  input  4  register selected for monitoring.
- monRFData  output  WIDTH  combinational contents of register monRFSrc.
- monInstr  output  WIDTH  instruction register.
- monPC  output  2*IRAM_ADDR_BITS  {PC, PCNext}.
- led  output  1  LED register.
- halted  output  1  core is in HALT.
- fault  output  1  sticky stack fault.

## Operation
- Fields: op=Instr[15:12], rd=[11:8], rb=[7:4], ra=[3:0], imm8=[7:0]. Branch offsets are sext(imm8), truncated to IRAM_ADDR_BITS.
- 0 ADD rd=ra+rb; 1 SUB rd=ra−rb; 2 AND; 3 OR. Each updates flags Z (result==0) and N (result MSB). Results wrap modulo 2^WIDTH.
- 4 LDL rd=zext(imm8). 5 LDH rd=(rd<<8)|imm8, upper bits discarded. Neither changes flags.
- 6 BZ: PC=PC+sext(imm8) if Z, else PC+1. 7 BRA: PC=PC+sext(imm8), always.
- 8 WAIT: enter WAITX. On the first EXEC-equivalent cycle with extCtl=1, set PC=PC+1 and go to FETCH.
- 9 CALL: push PC+1, then PC=zext(imm8). A RET: pop into PC.
- B OUT: led=rd[0]. F HALT: enter HALT. Opcodes C–E are NOPs (PC+1).
- FSM states: FETCH, EXEC, WAITX, HALT. Transitions: FETCH→EXEC→FETCH; EXEC→WAITX/HALT per opcode; WAITX→FETCH on extCtl; HALT is exited only by reset.
- Stack faults: CALL with a full stack, or RET with an empty stack, sets fault=1, goes to HALT, and leaves PC, stack and registers unchanged.
- PCNext = the value PC will load at the end of EXEC, computed from the current instruction and flags. In other states PCNext = PC.
- IRAM: synchronous read in FETCH. Writes are accepted in any state, including while running. A write and a read to the same address in the same cycle returns the old data. IRAM contents are not reset.

## Timing
- Reset values: state=FETCH, PC=0, Instr=0, Z=N=0, stack pointer=0 (empty), led=0, halted=0, fault=0. Registers are reset to 0 (16 entries × WIDTH).
- Each instruction takes 2 cycles with PCenable held high (FETCH, then EXEC). WAIT adds ≥1 cycle. HALT sets halted=1 on the cycle after its EXEC.
- Register, flag, led, stack and PC updates all commit on the clk edge that ends EXEC. monRFData reflects a write one cycle later.
- When PCenable is low, every state element holds, including WAITX, which ignores extCtl. IRAM writes still occur.
- Asserting reset mid-instruction aborts it. Writes pending at that edge are not committed.
- The PC increment wraps from 2^IRAM_ADDR_BITS−1 to 0, and branch targets wrap the same way.

## Test plan
- Program "LDL r1,5; LDL r2,3; SUB r3,r1,r2; HALT" loaded via iram_wen, run with PCenable=1 → r3=2, Z=0, halted=1 after 8 cycles, monPC={4,4}.
- Counter loop "LDL r1,3; LDL r2,1; SUB r1,r1,r2; BZ +2; BRA −2; HALT" → r1=0 at halt; BZ taken exactly once.
- LDL r4,0x12; LDH r4,0x34 → r4=0x1234. WAIT with extCtl held 0 for 10 cycles, then pulsed → PC stays, then advances by 1.
- CALL nesting to STACK_DEPTH then RET chain → returns to each PC+1. A CALL at depth STACK_DEPTH+1 → fault=1 and halted=1. RET at reset → fault=1.
- Toggle PCenable low for 5 cycles mid-EXEC → state, PC and monPC frozen; execution resumes identically. Assert reset mid-run → all outputs at reset values next cycle.
- OUT with r5=1, then OUT with r5=0 → led 1 then 0. PC at 0xFF with NOP → PC wraps to 0x00.
